// File: rtl/inst_rom_arbiter_pkg.sv
// Shared types and the grant-selection helper for the two-master instruction ROM arbiter.
`include "yadan_defs.sv"

package inst_rom_arbiter_pkg;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    typedef enum logic {
        LAST_M0 = 1'b0,
        LAST_M1 = 1'b1
    } last_gnt_e;

    // Returns {gnt1, gnt0}. Fixed priority always favours m0; round-robin
    // favours whichever master was not granted last when both are eligible.
    function automatic logic [1:0] arb_pick(
        input logic      fixed_prio,
        input last_gnt_e last_gnt,
        input logic      elig0,
        input logic      elig1
    );
        logic [1:0] pick;
        pick = 2'b00;
        if (elig0 && elig1) begin
            if (fixed_prio || (last_gnt == LAST_M1)) begin
                pick = 2'b01;
            end else begin
                pick = 2'b10;
            end
        end else if (elig0) begin
            pick = 2'b01;
        end else if (elig1) begin
            pick = 2'b10;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rd_resp_buf.sv
// One-entry read response buffer for a single master. A load in the same cycle as a drain
// replaces the data and stays FULL, so one read per cycle can be sustained.
`include "yadan_defs.sv"

module rd_resp_buf
    import inst_rom_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [`InstBus]  data_i,
    input  logic             rready_i,
    output logic             rvalid_o,
    output logic [`InstBus]  rdata_o,
    output logic             accept_o,
    output buf_state_e       state_o
);

    buf_state_e         state_q, state_d;
    logic [`InstBus]    data_q, data_d;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == `RstEnable) begin
            state_q <= BUF_EMPTY;
            data_q  <= `ZeroWord;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Data is cleared on drain so rdata_o reads zero whenever the entry is empty.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = BUF_FULL;
            data_d  = data_i;
        end else if ((state_q == BUF_FULL) && rready_i) begin
            state_d = BUF_EMPTY;
            data_d  = `ZeroWord;
        end
    end

    assign rvalid_o = (state_q == BUF_FULL);
    assign rdata_o  = data_q;
    assign accept_o = (state_q == BUF_EMPTY) || rready_i;
    assign state_o  = state_q;

endmodule

// File: rtl/yadan_defs.sv
// Shared bus widths and control encodings for the yadan core and its memory-side blocks.
// Guarded so that every file can include it no matter the compile order.
`ifndef YADAN_DEFS_SV
`define YADAN_DEFS_SV

`define RstEnable     1'b0
`define RstDisable    1'b1
`define ReadEnable    1'b1
`define ReadDisable   1'b0
`define ZeroWord      32'h00000000
`define InstAddrBus   31:0
`define InstBus       31:0

`define ArbRoundRobin 0
`define ArbFixedPrio  1

`endif

// File: rtl/inst_rom_arbiter.sv
// Arbitrates the core fetch port (m0) and the debug/loader port (m1) onto one combinational
// instruction ROM; each master gets its read word one cycle after its grant.
`include "yadan_defs.sv"

module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned RESET_LAST = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req_i,
    input  logic [`InstAddrBus] m0_addr_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [`InstBus]     m0_rdata_o,
    input  logic                m0_rready_i,

    input  logic                m1_req_i,
    input  logic [`InstAddrBus] m1_addr_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [`InstBus]     m1_rdata_o,
    input  logic                m1_rready_i,

    output logic                rom_ce_o,
    output logic [`InstAddrBus] rom_addr_o,
    input  logic [`InstBus]     rom_inst_i,

    output last_gnt_e           dbg_last_gnt_o,
    output buf_state_e          dbg_m0_buf_o,
    output buf_state_e          dbg_m1_buf_o
);

    localparam logic      FixedPrio = (ARB_MODE == `ArbFixedPrio);
    localparam last_gnt_e LastRst   = (RESET_LAST == 0) ? LAST_M0 : LAST_M1;

    last_gnt_e  last_q, last_d;
    logic       in_reset;
    logic       m0_accept, m1_accept;
    logic       m0_elig, m1_elig;
    logic [1:0] pick;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == `RstEnable) begin
            last_q <= LastRst;
        end else begin
            last_q <= last_d;
        end
    end

    // Grants are combinational, so they are gated by reset to go quiet immediately.
    always_comb begin
        in_reset   = (rst == `RstEnable);
        m0_elig    = m0_req_i && m0_accept;
        m1_elig    = m1_req_i && m1_accept;
        pick       = arb_pick(FixedPrio, last_q, m0_elig, m1_elig);
        m0_gnt_o   = pick[0] && !in_reset;
        m1_gnt_o   = pick[1] && !in_reset;
        rom_ce_o   = `ReadDisable;
        rom_addr_o = `ZeroWord;
        last_d     = last_q;
        if (m0_gnt_o) begin
            rom_ce_o   = `ReadEnable;
            rom_addr_o = m0_addr_i;
            last_d     = LAST_M0;
        end else if (m1_gnt_o) begin
            rom_ce_o   = `ReadEnable;
            rom_addr_o = m1_addr_i;
            last_d     = LAST_M1;
        end
    end

    rd_resp_buf u_m0_buf (
        .clk      (clk),
        .rst      (rst),
        .load_i   (m0_gnt_o),
        .data_i   (rom_inst_i),
        .rready_i (m0_rready_i),
        .rvalid_o (m0_rvalid_o),
        .rdata_o  (m0_rdata_o),
        .accept_o (m0_accept),
        .state_o  (dbg_m0_buf_o)
    );

    rd_resp_buf u_m1_buf (
        .clk      (clk),
        .rst      (rst),
        .load_i   (m1_gnt_o),
        .data_i   (rom_inst_i),
        .rready_i (m1_rready_i),
        .rvalid_o (m1_rvalid_o),
        .rdata_o  (m1_rdata_o),
        .accept_o (m1_accept),
        .state_o  (dbg_m1_buf_o)
    );

    assign dbg_last_gnt_o = last_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter: a round-robin and a fixed-priority instance share
// the master stimulus, each reading its own copy of a small combinational ROM.
module tb_inst_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_rready, m1_req, m1_rready;
    logic [31:0] m0_addr, m1_addr;

    logic        rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid, rr_rom_ce;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_rom_addr, rr_rom_inst;
    logic        rr_dbg_last, rr_dbg_b0, rr_dbg_b1;

    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_rom_ce;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_rom_addr, fp_rom_inst;
    logic        fp_dbg_last, fp_dbg_b0, fp_dbg_b1;

    logic [31:0] rom_mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] W0 = 32'h00000013;
    localparam logic [31:0] W1 = 32'h00500093;
    localparam logic [31:0] W2 = 32'h00100113;
    localparam logic [31:0] W3 = 32'hDEADBEEF;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rom_mem[0] = W0;
        rom_mem[1] = W1;
        rom_mem[2] = W2;
        rom_mem[3] = W3;
        for (int i = 4; i < 16; i++) rom_mem[i] = 32'hA000_0000 + 32'(i);
    end

    assign rr_rom_inst = rom_mem[rr_rom_addr[5:2]];
    assign fp_rom_inst = rom_mem[fp_rom_addr[5:2]];

    inst_rom_arbiter #(.ARB_MODE(0), .RESET_LAST(1)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(rr_m0_gnt),
        .m0_rvalid_o(rr_m0_rvalid), .m0_rdata_o(rr_m0_rdata), .m0_rready_i(m0_rready),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_gnt_o(rr_m1_gnt),
        .m1_rvalid_o(rr_m1_rvalid), .m1_rdata_o(rr_m1_rdata), .m1_rready_i(m1_rready),
        .rom_ce_o(rr_rom_ce), .rom_addr_o(rr_rom_addr), .rom_inst_i(rr_rom_inst),
        .dbg_last_gnt_o(rr_dbg_last), .dbg_m0_buf_o(rr_dbg_b0), .dbg_m1_buf_o(rr_dbg_b1)
    );

    inst_rom_arbiter #(.ARB_MODE(1), .RESET_LAST(1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(fp_m0_gnt),
        .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata), .m0_rready_i(m0_rready),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_gnt_o(fp_m1_gnt),
        .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata), .m1_rready_i(m1_rready),
        .rom_ce_o(fp_rom_ce), .rom_addr_o(fp_rom_addr), .rom_inst_i(fp_rom_inst),
        .dbg_last_gnt_o(fp_dbg_last), .dbg_m0_buf_o(fp_dbg_b0), .dbg_m1_buf_o(fp_dbg_b1)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at the falling edge; outputs are sampled 1ns later, well before the next rising edge.
    task automatic cyc(input logic q0, input logic [31:0] a0, input logic r0,
                       input logic q1, input logic [31:0] a1, input logic r1);
        @(negedge clk);
        m0_req = q0; m0_addr = a0; m0_rready = r0;
        m1_req = q1; m1_addr = a1; m1_rready = r1;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        idle();
        rst = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_rready = 1'b1;
        m1_req = 1'b0; m1_addr = '0; m1_rready = 1'b1;

        // Reset holds grants and the ROM port quiet even with both masters requesting.
        cyc(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 1'b1);
        check("rst_m0_gnt",   32'(rr_m0_gnt),    32'd0);
        check("rst_m1_gnt",   32'(rr_m1_gnt),    32'd0);
        check("rst_rom_ce",   32'(rr_rom_ce),    32'd0);
        check("rst_rom_addr", rr_rom_addr,       32'd0);
        check("rst_m0_rvalid",32'(rr_m0_rvalid), 32'd0);
        check("rst_m1_rdata", rr_m1_rdata,       32'd0);
        check("rst_last",     32'(rr_dbg_last),  32'd1);
        check("rst_fp_gnt",   {30'd0, fp_m1_gnt, fp_m0_gnt}, 32'd0);
        idle();
        rst = 1'b1;

        // Single m0 read of word 1, granted in the first cycle after release.
        cyc(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1);
        check("single_gnt",      32'(rr_m0_gnt),    32'd1);
        check("single_rom_ce",   32'(rr_rom_ce),    32'd1);
        check("single_rom_addr", rr_rom_addr,       32'h4);
        check("single_rv0_c0",   32'(rr_m0_rvalid), 32'd0);
        idle();
        check("single_rvalid",   32'(rr_m0_rvalid), 32'd1);
        check("single_rdata",    rr_m0_rdata,       W1);
        check("single_gnt_c1",   32'(rr_m0_gnt),    32'd0);
        idle();
        check("single_rv_off",   32'(rr_m0_rvalid), 32'd0);
        check("single_rd_zero",  rr_m0_rdata,       32'd0);

        // Round-robin alternation starting with m0; value is {gnt1, gnt0}.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1);
            check($sformatf("rr_alt_%0d", i), {30'd0, rr_m1_gnt, rr_m0_gnt},
                  (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i == 2) begin
                check("rr_m1_rvalid", 32'(rr_m1_rvalid), 32'd1);
                check("rr_m1_rdata",  rr_m1_rdata,       W2);
            end
        end

        // Fixed priority: m0 wins every cycle.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 1'b1);
            check($sformatf("fp_gnt_%0d", i), {30'd0, fp_m1_gnt, fp_m0_gnt}, 32'd1);
        end

        // m1 backpressure: data held, no regrant until rready returns.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1);
        check("bp_first_gnt", 32'(rr_m1_gnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0);
            check($sformatf("bp_hold_rv_%0d", i),  32'(rr_m1_rvalid), 32'd1);
            check($sformatf("bp_hold_rd_%0d", i),  rr_m1_rdata,       W2);
            check($sformatf("bp_hold_gnt_%0d", i), 32'(rr_m1_gnt),    32'd0);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1);
        check("bp_regrant",    32'(rr_m1_gnt), 32'd1);
        check("bp_regrant_rd", rr_m1_rdata,    W2);
        check("bp_rom_addr",   rr_rom_addr,    32'hC);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("bp_new_rdata",  rr_m1_rdata,    W3);

        // Asynchronous reset discards a full buffer.
        do_reset();
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("ar_full_rd", rr_m0_rdata, W3);
        #1 rst = 1'b0;
        #1;
        check("ar_rvalid", 32'(rr_m0_rvalid), 32'd0);
        check("ar_rdata",  rr_m0_rdata,       32'd0);
        idle();
        rst = 1'b1;
        idle();
        check("ar_no_stale", 32'(rr_m0_rvalid), 32'd0);
        idle();
        check("ar_no_stale2", 32'(rr_m0_rvalid), 32'd0);
        cyc(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1);
        check("ar_regrant", 32'(rr_m0_gnt), 32'd1);
        idle();
        check("ar_new_rd", rr_m0_rdata, W1);

        // Back-to-back m0 reads return in address order.
        do_reset();
        cyc(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("b2b_gnt0", 32'(rr_m0_gnt), 32'd1);
        cyc(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1);
        check("b2b_gnt1", 32'(rr_m0_gnt), 32'd1);
        check("b2b_rd0",  rr_m0_rdata,    W0);
        cyc(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b1);
        check("b2b_gnt2", 32'(rr_m0_gnt), 32'd1);
        check("b2b_rd1",  rr_m0_rdata,    W1);
        idle();
        check("b2b_rv2",  32'(rr_m0_rvalid), 32'd1);
        check("b2b_rd2",  rr_m0_rdata,       W2);
        idle();
        check("b2b_end",  32'(rr_m0_rvalid), 32'd0);

        // Same address from both masters: only the granted one is served.
        do_reset();
        cyc(1'b1, 32'h4, 1'b1, 1'b1, 32'h4, 1'b1);
        check("same_gnt", {30'd0, rr_m1_gnt, rr_m0_gnt}, 32'd1);
        idle();
        check("same_rv0", 32'(rr_m0_rvalid), 32'd1);
        check("same_rv1", 32'(rr_m1_rvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_rom_arbiter.md
INST_ROM_ARBITER -- requirements
Module: inst_rom_arbiter

Interface
REQ-001 Parameter ARB_MODE, default 0, 0 = round-robin, 1 = fixed priority with m0 highest.
REQ-002 Parameter RESET_LAST, default 1, last-granted master after reset; with it, m0 wins the first contested round-robin cycle.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (`RstEnable = 0).
REQ-005 m0_req_i  input  1  core instruction-fetch read request.
REQ-006 m0_addr_i  input  `InstAddrBus  m0 byte address.
REQ-007 m0_gnt_o  output  1  m0 request accepted this cycle.
REQ-008 m0_rvalid_o  output  1  m0 read data valid.
REQ-009 m0_rdata_o  output  `InstBus  m0 read data.
REQ-010 m0_rready_i  input  1  m0 accepts the read data.
REQ-011 m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_rready_i: same widths and meanings for the debug/loader read master.
REQ-012 rom_ce_o  output  1  ROM read enable (`ReadEnable / `ReadDisable).
REQ-013 rom_addr_o  output  `InstAddrBus  ROM address, passed through unmodified.
REQ-014 rom_inst_i  input  `InstBus  combinational ROM data, same cycle as rom_addr_o.

Function
REQ-015 A master is eligible when its req_i = 1 and its response buffer is empty, or is full and being drained this cycle (rvalid_o & rready_i).
REQ-016 At most one gnt_o is 1 per cycle; gnt_o is combinational from eligibility and arbiter state.
REQ-017 ARB_MODE 0: with both eligible, grant the master not granted last; with one eligible, grant it.
REQ-018 ARB_MODE 1: m0 is granted whenever it is eligible.
REQ-019 The last-grant pointer updates only in a cycle with a grant.
REQ-020 In a grant cycle, rom_ce_o = 1 and rom_addr_o = granted master's addr_i; otherwise rom_ce_o = 0 and rom_addr_o = 0.
REQ-021 In a grant cycle, rom_inst_i is captured into the granted master's buffer at the clock edge; rvalid_o = 1 from the next cycle (latency 1).
REQ-022 Each master's buffer states are EMPTY and FULL. A grant moves it to FULL. rvalid & rready with no new grant moves it to EMPTY. rvalid & rready with a new grant in the same cycle keeps it FULL with the new data (one read per cycle sustained).
REQ-023 While FULL and rready_i = 0, rdata_o and rvalid_o hold stable.
REQ-024 rdata_o is 0 whenever rvalid_o = 0.
REQ-025 A master that holds req_i = 1 without a grant keeps its request pending; the arbiter never drops it.
REQ-026 In ARB_MODE 0, a continuously eligible master is granted within 2 cycles.
REQ-027 If both masters present the same address in the same cycle, only the granted master is served that cycle.

Reset
REQ-028 Reset asserted (rst = 0) immediately forces: gnt_o = 0, rvalid_o = 0, rdata_o = 0 (both masters), rom_ce_o = 0, rom_addr_o = 0, buffers EMPTY, last-grant = RESET_LAST.
REQ-029 Reset asserted mid-transaction discards any buffered data; after release, no stale rvalid_o appears.
REQ-030 The first grant is possible in the first cycle after reset release.

Structure
REQ-031 Bus widths and enable constants come from yadan_defs.v (`InstAddrBus, `InstBus, `ReadEnable, `ReadDisable, `ZeroWord, `RstEnable); no local redefinitions.
REQ-032 Add ARB_MODE encodings `ArbRoundRobin and `ArbFixedPrio to yadan_defs.v.
REQ-033 Implement the per-master response buffer as one sub-module, rd_resp_buf, instantiated twice.

Verification
REQ-034 m0 only, addr 0x00000004, ROM word 1 = 0x00500093, rready = 1 -> gnt at cycle 0; rvalid with rdata 0x00500093 at cycle 1.
REQ-035 Both requesting continuously, ARB_MODE 0, both rready = 1 -> grants alternate m0, m1, m0, m1 starting with m0; no cycle has two grants.
REQ-036 ARB_MODE 1, both requesting for 5 cycles -> m0 is granted all 5 cycles; m1_gnt_o stays 0.
REQ-037 m1 rready = 0 for 3 cycles after its first grant at addr 0x8 -> m1_rdata_o is held at ROM word 2; m1_gnt_o = 0 until the drain cycle; regrant occurs in the same cycle rready returns to 1.
REQ-038 Reset asserted while m0 buffer is FULL with 0xDEADBEEF -> m0_rvalid_o and m0_rdata_o go to 0 asynchronously; after release, no rvalid until a new grant.
REQ-039 Back-to-back m0 reads of addrs 0x0, 0x4, 0x8 with rready = 1 -> three consecutive rvalid cycles in address order.
